// File: rtl/m_shift_accumulator.sv
// m_shift_accumulator
//   Sums the pre-shifted partial-product column vectors of every precision
//   pass of a tile into one full-precision result per column (lane).
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_ACCUM   | no partial tile held; the next accepted beat starts a tile
//   S_PARTIAL | one or more passes of the current tile are in acc_q
//
// Ports
//   clk, rst_n              clock and asynchronous active-low reset
//   clear                   synchronous flush of the tile in progress
//   in_valid/in_ready       input handshake, in_data lanes j*IN_W, signed
//   in_last                 final pass of the tile
//   out_valid/out_ready     output handshake, out_data lanes j*ACC_W, signed
//   out_passes              number of beats summed into out_data
//   err                     sticky: a tile was force-closed at MAX_PASSES
module m_shift_accumulator #(
  parameter int MPE_COL    = 8,
  parameter int IN_W       = 32,
  parameter int MAX_PASSES = 4,
  parameter int ACC_W      = IN_W + $clog2(MAX_PASSES) + 1,
  parameter int CNT_W      = $clog2(MAX_PASSES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MPE_COL*IN_W-1:0]  in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MPE_COL*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]         out_passes,
  output logic                     err
);

  localparam int EXT_W = ACC_W - IN_W;

  typedef enum logic [0:0] {
    S_ACCUM   = 1'b0,
    S_PARTIAL = 1'b1
  } state_t;

  state_t                   state_q;
  logic [MPE_COL*ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]         pass_cnt_q;
  logic                     out_valid_q;
  logic [MPE_COL*ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0]         out_passes_q;
  logic                     err_q;

  logic                     accept;
  logic                     at_max;
  logic                     close_d;
  logic [MPE_COL*ACC_W-1:0] sum_d;

  // Only a stalled output blocks the input; accumulation continues otherwise.
  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign at_max   = (pass_cnt_q == CNT_W'(MAX_PASSES - 1));
  // A beat that coincides with clear is swallowed and never closes a tile.
  assign close_d  = accept && !clear && (in_last || at_max);

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < MPE_COL; j++) begin
      sum_d[j*ACC_W +: ACC_W] =
          ((state_q == S_PARTIAL) ? acc_q[j*ACC_W +: ACC_W] : {ACC_W{1'b0}})
        + {{EXT_W{in_data[j*IN_W + IN_W - 1]}}, in_data[j*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ACCUM;
      acc_q        <= '0;
      pass_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_passes_q <= '0;
      err_q        <= 1'b0;
    end else begin
      // Accumulator / pass counter
      if (clear || close_d) begin
        state_q    <= S_ACCUM;
        acc_q      <= '0;
        pass_cnt_q <= '0;
      end else if (accept) begin
        state_q    <= S_PARTIAL;
        acc_q      <= sum_d;
        pass_cnt_q <= pass_cnt_q + 1'b1;
      end

      // Output register; a close in the transfer cycle reloads it without a bubble.
      if (close_d) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= sum_d;
        out_passes_q <= pass_cnt_q + 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q  <= 1'b0;
      end

      if (close_d && !in_last) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_passes = out_passes_q;
  assign err        = err_q;

endmodule

// File: doc/m_shift_accumulator.md
Name: m_shift_accumulator

Overview:
- Downstream of the MAC-array shifter stage: receives one column vector of sign-extended, pre-shifted partial products per precision pass and sums all passes of a tile into a full-precision result per column.
- Owns a pass counter, the tile-completion logic, a single-entry output register with valid/ready backpressure and a sticky protocol-error flag.
- Output feeds the array's writeback / requantisation stage.

Parameters:
- MPE_COL, 8, number of columns (lanes) processed in parallel.
- IN_W, 32, width of each shifted partial product, two's-complement signed.
- MAX_PASSES, 4, maximum precision passes per tile (4-bit slice decomposition of 8x8); must be >= 1.
- ACC_W, IN_W + $clog2(MAX_PASSES) + 1, per-lane accumulator width; sized so MAX_PASSES signed additions cannot overflow.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of the partial tile in progress.
- in_valid  input  1  partial-product vector valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  MPE_COL*IN_W  lane j at bits [j*IN_W +: IN_W], signed.
- in_last  input  1  beat is the final pass of the tile.
- out_valid  output  1  tile result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  MPE_COL*ACC_W  lane j at bits [j*ACC_W +: ACC_W], signed.
- out_passes  output  $clog2(MAX_PASSES+1)  number of beats summed into out_data.
- err  output  1  sticky: a tile was forcibly closed at MAX_PASSES without in_last.

Behaviour:
- Reset (rst_n low, asynchronous): acc = 0, pass_cnt = 0, out_valid = 0, out_data = 0, out_passes = 0, err = 0, state = ACCUM. Reset mid-tile discards all partial state.
- Handshake: a beat is accepted when in_valid && in_ready; results transfer when out_valid && out_ready.
- in_ready = !(out_valid && !out_ready). This is registered-state driven only and has no dependency on in_valid or in_last.
- Arithmetic: each lane sign-extends in_data to ACC_W and adds it to acc[j]. No saturation is needed because ACC_W guarantees headroom.
- States:
  - ACCUM (pass_cnt == 0): an accepted non-last beat loads acc = sext(in) and pass_cnt = 1, then moves to PARTIAL.
  - PARTIAL (pass_cnt > 0): an accepted non-last beat sets acc += sext(in) and pass_cnt += 1.
  - Tile close: an accepted beat with in_last = 1, or with pass_cnt == MAX_PASSES-1, completes the tile.
    - Next cycle: out_data = acc_sum (acc + sext(in), or sext(in) alone from ACCUM), out_passes = pass_cnt+1, out_valid = 1.
    - acc and pass_cnt are cleared and the state returns to ACCUM.
    - Latency from the last beat to out_valid is 1 cycle.
- Forced close: closing at pass_cnt == MAX_PASSES-1 with in_last = 0 sets err = 1. err stays set until reset; clear does not reset it.
- Single-beat tile: in_last on the first beat produces out_data = sext(in), out_passes = 1.
- Output register: holds its value while out_valid && !out_ready.
  - out_valid falls the cycle after the transfer, unless a new tile closes in the same cycle as the transfer. In that case out_valid stays 1 and out_data/out_passes update (back-to-back, no bubble).
  - Accumulation of a new tile continues while the output waits, as long as in_ready is high (in_ready is low only while the output is stalled).
- clear:
  - Next cycle: acc = 0, pass_cnt = 0, state = ACCUM.
  - If clear coincides with an accepted beat, the beat is consumed and discarded, and no tile close occurs even if in_last is set.
  - clear never affects out_valid, out_data, out_passes or err.
- With MAX_PASSES == 1, every beat closes a tile. err is set on any beat with in_last = 0.

Test Plan:
- 4-pass tile, lane 0 inputs 0x100, 0x10, -0x20, 0x1 with in_last on the 4th, out_ready = 1 -> out_valid one cycle after the 4th accept, lane 0 = 0xF1, out_passes = 4, err = 0.
- Single beat, in_last = 1, lane 3 = 0xFFFFFFFF (-1) -> lane 3 out = -1 sign-extended to ACC_W, out_passes = 1.
- 4 beats of +1 with in_last never asserted (MAX_PASSES = 4) -> result 4, out_passes = 4, err = 1. A subsequent normal tile keeps err = 1.
- out_ready held low while two tiles arrive -> first result held stable, in_ready low during the stall, second tile's beats wait. Releasing out_ready gives results 1 and 2 in order with no loss or duplication.
- Two beats accepted, then clear together with a third beat carrying in_last -> no out_valid. The next tile of 5 + 7 yields 12, out_passes = 2.
- rst_n pulsed low mid-tile and while out_valid is set -> all outputs 0 immediately (asynchronously). The next tile's result excludes pre-reset data.
